// File: rtl/uiuart_rx.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling via a baud counter,
// registered one-cycle rvalid / frame_err pulses.
module uiuart_rx #(
  parameter int BAUD_DIV = 10416
) (
  input  logic       I_clk,
  input  logic       I_uart_rstn,
  input  logic       I_uart_rx,
  output logic [7:0] O_uart_rdata,
  output logic       O_uart_rvalid,
  output logic       O_uart_rbusy,
  output logic       O_uart_frame_err
);

  localparam logic [13:0] DIV  = 14'(BAUD_DIV);
  localparam logic [13:0] HALF = 14'(BAUD_DIV / 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, rx_s_q, rx_d_q;
  logic [13:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // Edge-triggered start: a line already low never opens a frame.
        if (rx_d_q && !rx_s_q) begin
          state_d = START;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_q == HALF) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          baud_d = baud_q + 14'd1;
        end
      end
      DATA: begin
        if (baud_q == DIV) begin
          shift_d[bit_q] = rx_s_q;
          baud_d         = '0;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 14'd1;
        end
      end
      STOP: begin
        if (baud_q == DIV) begin
          baud_d  = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            rdata_d  = shift_q;
            rvalid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 14'd1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge I_clk or negedge I_uart_rstn) begin
    if (!I_uart_rstn) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      rx_d_q   <= 1'b1;
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync1_q  <= I_uart_rx;
      rx_s_q   <= sync1_q;
      rx_d_q   <= rx_s_q;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

  assign O_uart_rdata     = rdata_q;
  assign O_uart_rvalid    = rvalid_q;
  assign O_uart_rbusy     = busy_q;
  assign O_uart_frame_err = ferr_q;

endmodule

// File: tb/tb_uiuart_rx.sv
// Directed bench for uiuart_rx at BAUD_DIV=15 (16 cycles per bit).
module tb_uiuart_rx;
  localparam int BAUD_DIV = 15;
  localparam int P = BAUD_DIV + 1;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rdata;
  logic       rvalid, rbusy, ferr;

  int tests = 0;
  int fails = 0;

  uiuart_rx #(.BAUD_DIV(BAUD_DIV)) dut (
    .I_clk(clk),
    .I_uart_rstn(rstn),
    .I_uart_rx(rx),
    .O_uart_rdata(rdata),
    .O_uart_rvalid(rvalid),
    .O_uart_rbusy(rbusy),
    .O_uart_frame_err(ferr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: event counters sampled on the falling edge.
  int         rv_cnt = 0, fe_cnt = 0, busy_cnt = 0;
  int         both_cnt = 0, long_cnt = 0, bad_chg = 0;
  logic       prev_rv = 1'b0, prev_fe = 1'b0;
  logic [7:0] prev_rdata = 8'h00;
  logic [7:0] rx_q[$];
  int         rv_t[$];

  always @(negedge clk) begin
    if (rstn) begin
      if (rvalid) begin
        rv_cnt = rv_cnt + 1;
        rx_q.push_back(rdata);
        rv_t.push_back(cyc);
      end
      if (ferr) fe_cnt = fe_cnt + 1;
      if (rbusy) busy_cnt = busy_cnt + 1;
      if (rvalid && ferr) both_cnt = both_cnt + 1;
      if ((rvalid && prev_rv) || (ferr && prev_fe)) long_cnt = long_cnt + 1;
      if (rdata !== prev_rdata && !rvalid) bad_chg = bad_chg + 1;
    end
    prev_rv    = rvalid;
    prev_fe    = ferr;
    prev_rdata = rdata;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (P) @(negedge clk);
    end
    rx = stop;
    repeat (P) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx = ~rx;
      tests++;
      if (rdata !== 8'h00 || rvalid !== 1'b0 || ferr !== 1'b0 || rbusy !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs: rdata=%h rvalid=%b ferr=%b rbusy=%b, want 00 0 0 0",
                 rdata, rvalid, ferr, rbusy);
      end
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single();
    int r0 = rv_cnt, f0 = fe_cnt, b0 = busy_cnt;
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    tests++;
    if (rv_cnt - r0 !== 1) begin fails++; $display("FAIL single_rvalid_count: got %0d want 1", rv_cnt - r0); end
    tests++;
    if (rdata !== 8'hA5) begin fails++; $display("FAIL single_rdata: got %h want a5", rdata); end
    tests++;
    if (fe_cnt - f0 !== 0) begin fails++; $display("FAIL single_ferr: got %0d want 0", fe_cnt - f0); end
    tests++;
    if (busy_cnt - b0 !== 152) begin fails++; $display("FAIL single_busy_cycles: got %0d want 152", busy_cnt - b0); end
    tests++;
    if (rbusy !== 1'b0) begin fails++; $display("FAIL single_busy_idle: got %b want 0", rbusy); end
  endtask

  task automatic test_back_to_back();
    int r0 = rv_cnt, b0 = busy_cnt, n;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    n = rx_q.size();
    tests++;
    if (rv_cnt - r0 !== 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d want 2", rv_cnt - r0);
    end else begin
      tests++;
      if (rx_q[n-2] !== 8'h00) begin fails++; $display("FAIL b2b_first: got %h want 00", rx_q[n-2]); end
      tests++;
      if (rx_q[n-1] !== 8'hFF) begin fails++; $display("FAIL b2b_second: got %h want ff", rx_q[n-1]); end
      tests++;
      if (rv_t[n-1] - rv_t[n-2] !== 160) begin
        fails++;
        $display("FAIL b2b_spacing: got %0d want 160", rv_t[n-1] - rv_t[n-2]);
      end
    end
    tests++;
    if (busy_cnt - b0 !== 304) begin fails++; $display("FAIL b2b_busy_cycles: got %0d want 304", busy_cnt - b0); end
  endtask

  task automatic test_glitch();
    int r0 = rv_cnt, f0 = fe_cnt, b0 = busy_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    tests++;
    if (rv_cnt - r0 !== 0) begin fails++; $display("FAIL glitch_rvalid: got %0d want 0", rv_cnt - r0); end
    tests++;
    if (fe_cnt - f0 !== 0) begin fails++; $display("FAIL glitch_ferr: got %0d want 0", fe_cnt - f0); end
    tests++;
    if (busy_cnt - b0 !== 8) begin fails++; $display("FAIL glitch_busy_cycles: got %0d want 8", busy_cnt - b0); end
    tests++;
    if (rbusy !== 1'b0) begin fails++; $display("FAIL glitch_busy_idle: got %b want 0", rbusy); end
  endtask

  task automatic test_frame_err();
    int r0 = rv_cnt, f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if (fe_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - f0); end
    tests++;
    if (rv_cnt - r0 !== 0) begin fails++; $display("FAIL ferr_rvalid: got %0d want 0", rv_cnt - r0); end
    tests++;
    if (rdata !== 8'hFF) begin fails++; $display("FAIL ferr_rdata_hold: got %h want ff", rdata); end
    send_frame(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    tests++;
    if (rv_cnt - r0 !== 1) begin fails++; $display("FAIL after_ferr_count: got %0d want 1", rv_cnt - r0); end
    tests++;
    if (rdata !== 8'h55) begin fails++; $display("FAIL after_ferr_rdata: got %h want 55", rdata); end
    tests++;
    if (fe_cnt - f0 !== 1) begin fails++; $display("FAIL after_ferr_ferr: got %0d want 1", fe_cnt - f0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'h5A;
    int r0, f0;
    rx = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (P) @(negedge clk);
    end
    rstn = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    tests++;
    if (rdata !== 8'h00 || rbusy !== 1'b0 || rvalid !== 1'b0 || ferr !== 1'b0) begin
      fails++;
      $display("FAIL midreset_outputs: rdata=%h rbusy=%b rvalid=%b ferr=%b, want 00 0 0 0",
               rdata, rbusy, rvalid, ferr);
    end
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    r0 = rv_cnt;
    f0 = fe_cnt;
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    tests++;
    if (rv_cnt - r0 !== 1) begin fails++; $display("FAIL midreset_count: got %0d want 1", rv_cnt - r0); end
    tests++;
    if (rdata !== 8'h81) begin fails++; $display("FAIL midreset_rdata: got %h want 81", rdata); end
    tests++;
    if (fe_cnt - f0 !== 0) begin fails++; $display("FAIL midreset_ferr: got %0d want 0", fe_cnt - f0); end
  endtask

  task automatic test_loopback();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int r0 = rv_cnt, f0 = fe_cnt;
    rx_q.delete();
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(255, 0));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    repeat (20) @(negedge clk);
    tests++;
    if (rv_cnt - r0 !== 256) begin fails++; $display("FAIL loop_count: got %0d want 256", rv_cnt - r0); end
    tests++;
    if (fe_cnt - f0 !== 0) begin fails++; $display("FAIL loop_ferr: got %0d want 0", fe_cnt - f0); end
    for (int i = 0; i < 256 && i < rx_q.size(); i++) begin
      tests++;
      if (rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL loop_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_invariants();
    tests++;
    if (both_cnt !== 0) begin fails++; $display("FAIL pulse_overlap: got %0d want 0", both_cnt); end
    tests++;
    if (long_cnt !== 0) begin fails++; $display("FAIL pulse_width: got %0d long pulses want 0", long_cnt); end
    tests++;
    if (bad_chg !== 0) begin fails++; $display("FAIL rdata_without_rvalid: got %0d want 0", bad_chg); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_loopback();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
